alu_issue_stage: RTL and testbench

//  ID->EX issue register feeding the ALU. Decodes one 32-bit MIPS instruction plus register-file reads

---
 rtl/mips_pkg.sv | 63 ++++++
 rtl/alu_op_decode.sv | 67 ++++++
 rtl/alu_issue_stage.sv | 113 +++++++++++
 tb/tb_alu_issue_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants for the ID->EX issue stage: opcodes, functs,
// ALU operation codes, side-band control bit positions and the decode record.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLL = 3'd4,
        ALU_SRL = 3'd5,
        ALU_CMP = 3'd6,
        ALU_SLT = 3'd7
    } aluop_e;

    // Bit positions inside the 6-bit side-band control word
    localparam int CTRL_W         = 6;
    localparam int CTRL_REG_WRITE = 5;
    localparam int CTRL_MEM_READ  = 4;
    localparam int CTRL_MEM_WRITE = 3;
    localparam int CTRL_BRANCH    = 2;
    localparam int CTRL_BRANCH_NE = 1;
    localparam int CTRL_ILLEGAL   = 0;

    typedef enum logic [1:0] {
        IN2_RT   = 2'd0,
        IN2_SEXT = 2'd1,
        IN2_ZEXT = 2'd2
    } in2_sel_e;

    typedef struct packed {
        aluop_e              aluop;
        logic                in1_rt;
        in2_sel_e            in2_sel;
        logic [4:0]          shamt;
        logic [4:0]          dest;
        logic [CTRL_W-1:0]   ctrl;
    } dec_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational MIPS instruction decode into ALU op, operand selects,
// shift amount, destination register and EX side-band controls.
module alu_op_decode
    import mips_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic [4:0] i_rt,
    input  logic [4:0] i_rd,
    input  logic [4:0] i_shamt,
    output dec_t       o_dec
);

    always_comb begin
        o_dec         = '0;
        o_dec.aluop   = ALU_ADD;
        o_dec.in2_sel = IN2_RT;
        case (i_opcode)
            OP_RTYPE: begin
                o_dec.dest                 = i_rd;
                o_dec.ctrl[CTRL_REG_WRITE] = 1'b1;
                case (i_funct)
                    FN_ADD: o_dec.aluop = ALU_ADD;
                    FN_SUB: o_dec.aluop = ALU_SUB;
                    FN_AND: o_dec.aluop = ALU_AND;
                    FN_OR:  o_dec.aluop = ALU_OR;
                    FN_SLT: o_dec.aluop = ALU_SLT;
                    FN_SLL, FN_SRL: begin
                        o_dec.aluop  = (i_funct == FN_SLL) ? ALU_SLL : ALU_SRL;
                        o_dec.in1_rt = 1'b1;
                        o_dec.shamt  = i_shamt;
                    end
                    default: begin
                        o_dec.dest               = '0;
                        o_dec.ctrl               = '0;
                        o_dec.ctrl[CTRL_ILLEGAL] = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                o_dec.aluop = (i_opcode == OP_ADDI) ? ALU_ADD :
                              (i_opcode == OP_ANDI) ? ALU_AND : ALU_OR;
                o_dec.in2_sel              = (i_opcode == OP_ADDI) ? IN2_SEXT : IN2_ZEXT;
                o_dec.dest                 = i_rt;
                o_dec.ctrl[CTRL_REG_WRITE] = 1'b1;
            end
            OP_LW: begin
                o_dec.in2_sel              = IN2_SEXT;
                o_dec.dest                 = i_rt;
                o_dec.ctrl[CTRL_REG_WRITE] = 1'b1;
                o_dec.ctrl[CTRL_MEM_READ]  = 1'b1;
            end
            OP_SW: begin
                o_dec.in2_sel              = IN2_SEXT;
                o_dec.ctrl[CTRL_MEM_WRITE] = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                o_dec.aluop                = ALU_CMP;
                o_dec.ctrl[CTRL_BRANCH]    = 1'b1;
                o_dec.ctrl[CTRL_BRANCH_NE] = (i_opcode == OP_BNE);
            end
            // Unknown opcodes still issue so EX can raise the exception
            default: o_dec.ctrl[CTRL_ILLEGAL] = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue register: decodes an instruction plus register reads into ALU
// controls and holds them behind a valid/ready handshake with optional skid entry.
module alu_issue_stage
    import mips_pkg::*;
#(
    parameter int DW   = 32,
    parameter int SKID = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic [DW-1:0] in_rs_data,
    input  logic [DW-1:0] in_rt_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_aluop,
    output logic [DW-1:0] out_in1,
    output logic [DW-1:0] out_in2,
    output logic [4:0]    out_shamt,
    output logic [4:0]    out_dest,
    output logic [5:0]    out_ctrl
);

    localparam int PW = 3 + DW + DW + 5 + 5 + CTRL_W;

    dec_t            w_dec;
    logic [DW-1:0]   w_in1_p0;
    logic [DW-1:0]   w_in2_p0;
    logic [PW-1:0]   w_pay_p0;
    logic            w_in_ready;
    logic            w_accept;
    state_e          w_state_nxt;
    logic            w_unused_rs;

    state_e          r_state;
    logic            r_in_ready;
    logic [PW-1:0]   r_out_p1;
    logic [PW-1:0]   r_skid_p1;

    // rs index is resolved by the register file upstream; only its data is used here
    assign w_unused_rs = &{1'b0, in_instr[25:21]};

    alu_op_decode u_decode (
        .i_opcode (in_instr[31:26]),
        .i_funct  (in_instr[5:0]),
        .i_rt     (in_instr[20:16]),
        .i_rd     (in_instr[15:11]),
        .i_shamt  (in_instr[10:6]),
        .o_dec    (w_dec)
    );

    always_comb begin
        w_in1_p0 = w_dec.in1_rt ? in_rt_data : in_rs_data;
        case (w_dec.in2_sel)
            IN2_SEXT: w_in2_p0 = {{(DW-16){in_instr[15]}}, in_instr[15:0]};
            IN2_ZEXT: w_in2_p0 = {{(DW-16){1'b0}}, in_instr[15:0]};
            default:  w_in2_p0 = in_rt_data;
        endcase
    end

    assign w_pay_p0   = {w_dec.aluop, w_in1_p0, w_in2_p0, w_dec.shamt, w_dec.dest, w_dec.ctrl};
    assign w_in_ready = (SKID != 0) ? r_in_ready : ((r_state == ST_EMPTY) || out_ready);
    assign w_accept   = in_valid && w_in_ready && !flush;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_accept && !out_ready)      w_state_nxt = ST_TWO;
                    else if (!w_accept && out_ready) w_state_nxt = ST_EMPTY;
                end
                ST_TWO:   if (out_ready) w_state_nxt = ST_ONE;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Capture stage boundary: decoded payload lands in the output or skid register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            r_out_p1   <= '0;
            r_skid_p1  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
            if (!flush) begin
                case (r_state)
                    ST_EMPTY: if (w_accept) r_out_p1 <= w_pay_p0;
                    ST_ONE: begin
                        if (w_accept && out_ready)  r_out_p1  <= w_pay_p0;
                        else if (w_accept)          r_skid_p1 <= w_pay_p0;
                    end
                    ST_TWO:   if (out_ready) r_out_p1 <= r_skid_p1;
                    default: ;
                endcase
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign {out_aluop, out_in1, out_in2, out_shamt, out_dest, out_ctrl} = r_out_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage against a queue-based reference model
// that decodes instructions straight from the MIPS field definitions.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [2:0]  aluop;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  shamt;
        logic [4:0]  dest;
        logic [5:0]  ctrl;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_rs_data = '0;
    logic [31:0] in_rt_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_aluop;
    logic [31:0] out_in1;
    logic [31:0] out_in2;
    logic [4:0]  out_shamt;
    logic [4:0]  out_dest;
    logic [5:0]  out_ctrl;

    int n_checks = 0;
    int n_fail   = 0;
    item_t q[$];

    alu_issue_stage #(.DW(32), .SKID(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_rs_data (in_rs_data),
        .in_rt_data (in_rt_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_aluop  (out_aluop),
        .out_in1    (out_in1),
        .out_in2    (out_in2),
        .out_shamt  (out_shamt),
        .out_dest   (out_dest),
        .out_ctrl   (out_ctrl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic item_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        item_t it;
        logic [5:0]  op, fn;
        logic [4:0]  rtn, rdn;
        logic [31:0] sx, zx;
        op  = ins[31:26];
        fn  = ins[5:0];
        rtn = ins[20:16];
        rdn = ins[15:11];
        sx  = {{16{ins[15]}}, ins[15:0]};
        zx  = {16'h0000, ins[15:0]};
        // ctrl bits: reg_write, mem_read, mem_write, branch, branch_ne, illegal
        it = '{aluop: 3'd0, in1: rs, in2: rt, shamt: 5'd0, dest: 5'd0, ctrl: 6'b000001};
        if (op == 6'h00) begin
            case (fn)
                6'h20: it = '{3'd0, rs, rt, 5'd0, rdn, 6'b100000};
                6'h22: it = '{3'd1, rs, rt, 5'd0, rdn, 6'b100000};
                6'h24: it = '{3'd2, rs, rt, 5'd0, rdn, 6'b100000};
                6'h25: it = '{3'd3, rs, rt, 5'd0, rdn, 6'b100000};
                6'h2A: it = '{3'd7, rs, rt, 5'd0, rdn, 6'b100000};
                6'h00: it = '{3'd4, rt, rt, ins[10:6], rdn, 6'b100000};
                6'h02: it = '{3'd5, rt, rt, ins[10:6], rdn, 6'b100000};
                default: ;
            endcase
        end else if (op == 6'h08) it = '{3'd0, rs, sx, 5'd0, rtn, 6'b100000};
        else if (op == 6'h0C)     it = '{3'd2, rs, zx, 5'd0, rtn, 6'b100000};
        else if (op == 6'h0D)     it = '{3'd3, rs, zx, 5'd0, rtn, 6'b100000};
        else if (op == 6'h23)     it = '{3'd0, rs, sx, 5'd0, rtn, 6'b110000};
        else if (op == 6'h2B)     it = '{3'd0, rs, sx, 5'd0, 5'd0, 6'b001000};
        else if (op == 6'h04)     it = '{3'd6, rs, rt, 5'd0, 5'd0, 6'b000100};
        else if (op == 6'h05)     it = '{3'd6, rs, rt, 5'd0, 5'd0, 6'b000110};
        return it;
    endfunction

    // One clock cycle: drive, check against model at negedge, advance model at posedge
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, input logic ordy, input logic fl);
        logic  acc, pop;
        item_t nxt;
        in_valid   = v;
        in_instr   = ins;
        in_rs_data = rs;
        in_rt_data = rt;
        out_ready  = ordy;
        flush      = fl;
        @(negedge clk);
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() != 0)
            chk("payload", {out_aluop, out_in1, out_in2, out_shamt, out_dest, out_ctrl}, q[0]);
        acc = v && (q.size() < 2) && !fl;
        pop = ordy && (q.size() != 0);
        nxt = model(ins, rs, rt);
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(nxt);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops[10] = '{6'h00, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h3F};
        logic [5:0] fns[8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h11};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[31:26] = ops[$urandom_range(0, 9)];
        else                           w[31:26] = 6'($urandom);
        if ($urandom_range(0, 9) != 0) w[5:0] = fns[$urandom_range(0, 7)];
        return w;
    endfunction

    localparam logic [31:0] I_ADD  = 32'h00221820;  // add $3,$1,$2
    localparam logic [31:0] I_ADDI = 32'h2022FFFC;  // addi $2,$1,-4
    localparam logic [31:0] I_ANDI = 32'h3022FFFC;  // andi $2,$1,0xFFFC
    localparam logic [31:0] I_SLL  = 32'h000220C0;  // sll $4,$2,3
    localparam logic [31:0] I_BNE  = 32'h14220010;  // bne $1,$2,16
    localparam logic [31:0] I_BAD  = 32'hFC000000;  // opcode 0x3F

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_data", {out_aluop, out_in1, out_in2, out_shamt, out_dest, out_ctrl}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed decode cases
        step(1, I_ADD, 32'd5, 32'd7, 1, 0);
        chk("add_aluop", out_aluop, 0);
        chk("add_in1", out_in1, 5);
        chk("add_in2", out_in2, 7);
        chk("add_dest", out_dest, 3);
        chk("add_rw", out_ctrl[5], 1);
        step(1, I_ADDI, 32'd10, 32'd0, 1, 0);
        chk("addi_in2", out_in2, 32'hFFFFFFFC);
        step(1, I_ANDI, 32'd10, 32'd0, 1, 0);
        chk("andi_in2", out_in2, 32'h0000FFFC);
        chk("andi_aluop", out_aluop, 2);
        step(1, I_SLL, 32'd9, 32'd1, 1, 0);
        chk("sll_aluop", out_aluop, 4);
        chk("sll_in1", out_in1, 1);
        chk("sll_shamt", out_shamt, 3);
        chk("sll_dest", out_dest, 4);
        step(1, I_BNE, 32'd1, 32'd2, 1, 0);
        chk("bne_aluop", out_aluop, 6);
        chk("bne_br", out_ctrl[2:1], 2'b11);
        chk("bne_dest", out_dest, 0);
        step(1, I_BAD, 32'd1, 32'd2, 1, 0);
        chk("bad_illegal", out_ctrl[0], 1);
        chk("bad_rw", out_ctrl[5], 0);
        step(0, 0, 0, 0, 1, 0);

        // Backpressure: A,B fill the stage, C is refused, then drains in order
        step(1, I_ADD,  32'hA, 32'h1, 0, 0);
        step(1, I_ADDI, 32'hB, 32'h2, 0, 0);
        chk("bp_in_ready", in_ready, 0);
        step(1, I_SLL,  32'hC, 32'h3, 0, 0);
        step(1, I_SLL,  32'hC, 32'h3, 1, 0);
        step(1, I_SLL,  32'hC, 32'h3, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        // Flush while full with a simultaneous valid input
        step(1, I_ADD, 32'h11, 32'h22, 0, 0);
        step(1, I_ADD, 32'h33, 32'h44, 0, 0);
        step(1, I_BNE, 32'h55, 32'h66, 0, 1);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        step(0, 0, 0, 0, 1, 0);

        // Asynchronous reset while full
        step(1, I_ADD, 32'h1, 32'h2, 0, 0);
        step(1, I_ADD, 32'h3, 32'h4, 0, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_data", {out_aluop, out_in1, out_in2, out_shamt, out_dest, out_ctrl}, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
